ahb_lite_master_port: RTL and testbench

Downstream consumer of the transaction request FIFO. Pops {write, size, addr, data} requests over a valid/ready handshake and drives them onto the AHB-Lite bus as pipelined SINGLE transfers. Handles HREADY wait states and the two-cycle ERROR response. Returns one in-order response per accepted request (read data or write completion, plus error flag).

---
 rtl/ahb_lite_pkg.sv | 35 +++
 rtl/ahb_lite_master_port_if.sv | 44 ++++
 rtl/ahb_lite_master_port.sv | 124 ++++++++++++
 tb/tb_ahb_lite_master_port.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the request record exchanged with the request FIFO.
package ahb_lite_pkg;

  localparam int unsigned AHB_BUS_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef struct packed {
    logic                     write;
    logic [2:0]               size;
    logic [AHB_BUS_WIDTH-1:0] addr;
    logic [AHB_BUS_WIDTH-1:0] data;
  } ahb_req_t;

  // A transfer is illegal if wider than the bus or not naturally aligned to its size.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [6:0] addr_lo,
                                         input logic [2:0] max_size);
    logic [6:0] mask;
    mask = (7'd1 << size) - 7'd1;
    return (size > max_size) || ((addr_lo & mask) != 7'd0);
  endfunction

endpackage

// File: rtl/ahb_lite_master_port_if.sv
// Request/response handshake plus AHB-Lite master signals for ahb_lite_master_port.
interface ahb_lite_master_port_if #(
  parameter int unsigned BUS_WIDTH = 32
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [2:0]           req_size;
  logic [BUS_WIDTH-1:0] req_addr;
  logic [BUS_WIDTH-1:0] req_wdata;

  logic                 rsp_valid;
  logic                 rsp_write;
  logic [BUS_WIDTH-1:0] rsp_rdata;
  logic                 rsp_error;

  logic [BUS_WIDTH-1:0] HADDR;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [2:0]           HBURST;
  logic [1:0]           HTRANS;
  logic [3:0]           HPROT;
  logic                 HMASTLOCK;
  logic [BUS_WIDTH-1:0] HWDATA;
  logic [BUS_WIDTH-1:0] HRDATA;
  logic                 HREADY;
  logic                 HRESP;

  // Port side: consumes requests and slave responses, drives the bus.
  modport master (
    input  req_valid, req_write, req_size, req_addr, req_wdata, HRDATA, HREADY, HRESP,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error,
    output HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HMASTLOCK, HWDATA
  );

  // Environment side: request source, response sink and AHB slave.
  modport slave (
    output req_valid, req_write, req_size, req_addr, req_wdata, HRDATA, HREADY, HRESP,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error,
    input  HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HMASTLOCK, HWDATA
  );

endinterface

// File: rtl/ahb_lite_master_port.sv
// AHB-Lite master port: pops FIFO requests and issues them as pipelined SINGLE transfers,
// returning one in-order response per request.
module ahb_lite_master_port
  import ahb_lite_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input logic                    clk,
  input logic                    resetn,
  ahb_lite_master_port_if.master bus
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(BUS_WIDTH / 8));

  typedef struct packed {
    logic                 valid;
    logic                 write;
    logic [2:0]           size;
    logic [BUS_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0] wdata;
    logic                 misaligned;
  } a_slot_t;

  // Address and size are no longer needed once a transfer reaches its data phase.
  typedef struct packed {
    logic                 valid;
    logic                 write;
    logic [BUS_WIDTH-1:0] wdata;
    logic                 misaligned;
  } d_slot_t;

  a_slot_t              a_q, a_d;
  d_slot_t              d_q, d_d;
  logic                 cancel_q, cancel_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_write_q, rsp_write_d;
  logic                 rsp_error_q, rsp_error_d;
  logic [BUS_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 req_ready;
  logic                 req_fire;

  assign req_ready = resetn & bus.HREADY & ~cancel_q;
  assign req_fire  = bus.req_valid & req_ready;

  // Pipeline advance, completion and ERROR-cancel next-state logic.
  always_comb begin
    a_d         = a_q;
    d_d         = d_q;
    cancel_d    = cancel_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;

    if (bus.HREADY) begin
      if (d_q.valid) begin
        rsp_valid_d = 1'b1;
        rsp_write_d = d_q.write;
        rsp_error_d = bus.HRESP | d_q.misaligned;
        rsp_rdata_d = (!d_q.write && !d_q.misaligned) ? bus.HRDATA : '0;
      end
      if (cancel_q) begin
        // Bus sampled IDLE this edge, so A stays pending and is re-driven next cycle.
        cancel_d  = 1'b0;
        d_d.valid = 1'b0;
      end else begin
        d_d.valid      = a_q.valid;
        d_d.write      = a_q.write;
        d_d.wdata      = a_q.wdata;
        d_d.misaligned = a_q.misaligned;
        a_d.valid      = req_fire;
        if (req_fire) begin
          a_d.write      = bus.req_write;
          a_d.size       = bus.req_size;
          a_d.addr       = bus.req_addr;
          a_d.wdata      = bus.req_wdata;
          a_d.misaligned = is_misaligned(bus.req_size, bus.req_addr[6:0], MAX_SIZE);
        end
      end
    end else if (bus.HRESP) begin
      // First ERROR cycle: suppress the pending address phase.
      cancel_d = 1'b1;
    end
  end

  // Slot, cancel and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q         <= '0;
      d_q         <= '0;
      cancel_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      a_q         <= a_d;
      d_q         <= d_d;
      cancel_q    <= cancel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  assign bus.HTRANS    = (a_q.valid && !a_q.misaligned && !cancel_q) ? HTRANS_NONSEQ
                                                                     : HTRANS_IDLE;
  assign bus.HADDR     = a_q.addr;
  assign bus.HWRITE    = a_q.write;
  assign bus.HSIZE     = a_q.size;
  assign bus.HWDATA    = d_q.wdata;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master_port.sv
// Self-checking bench for ahb_lite_master_port: directed scenarios plus a randomized run
// against a transaction-level reference model with a behavioural AHB slave.
module tb_ahb_lite_master_port;
  import ahb_lite_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ahb_lite_master_port_if #(.BUS_WIDTH(32)) bus ();

  ahb_lite_master_port #(.BUS_WIDTH(32), .HPROT_VAL(4'b0011)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    logic        w;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          mis;
    int          seq;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        bus_q[$];
  bit          out_err[int];
  logic [31:0] out_rdata[int];

  task automatic drive_req(input logic v, input logic w, input logic [2:0] s,
                           input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_size  = s;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  task automatic set_slave(input logic rdy, input logic resp, input logic [31:0] rdata);
    bus.HREADY = rdy;
    bus.HRESP  = resp;
    bus.HRDATA = rdata;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    set_slave(1'b1, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK} !==
        {2'b00, 1'b0, 3'd0, 3'b000, 4'b0011, 1'b0}) begin
      failures++;
      $display("FAIL rst_ctrl got=%b/%b/%h/%h/%h/%b", bus.HTRANS, bus.HWRITE, bus.HSIZE,
               bus.HBURST, bus.HPROT, bus.HMASTLOCK);
    end
    checks++;
    if ({bus.HADDR, bus.HWDATA} !== 64'h0) begin
      failures++;
      $display("FAIL rst_addr_data got=%h/%h exp=0/0", bus.HADDR, bus.HWDATA);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_write, bus.rsp_error, bus.rsp_rdata, bus.req_ready} !== 36'h0)
    begin
      failures++;
      $display("FAIL rst_rsp got=%b%b%b rdata=%h ready=%b exp all 0", bus.rsp_valid,
               bus.rsp_write, bus.rsp_error, bus.rsp_rdata, bus.req_ready);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready_after got=%b exp=1", bus.req_ready);
    end
  endtask

  task automatic test_single_write();
    drive_req(1'b1, 1'b1, HSIZE_WORD, 32'h0000_0010, 32'hDEAD_BEEF);
    set_slave(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    checks++;
    if ({bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE} !== {HTRANS_NONSEQ, 32'h10, 1'b1, 3'd2})
    begin
      failures++;
      $display("FAIL sw_addr_phase got=%h/%h/%b/%h exp=2/10/1/2", bus.HTRANS, bus.HADDR,
               bus.HWRITE, bus.HSIZE);
    end
    @(negedge clk);
    checks++;
    if ({bus.HTRANS, bus.HWDATA, bus.rsp_valid} !== {HTRANS_IDLE, 32'hDEAD_BEEF, 1'b0}) begin
      failures++;
      $display("FAIL sw_data_phase got=%h/%h/%b exp=0/deadbeef/0", bus.HTRANS, bus.HWDATA,
               bus.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_write, bus.rsp_error, bus.rsp_rdata} !== {3'b110, 32'h0}) begin
      failures++;
      $display("FAIL sw_rsp got=%b%b%b/%h exp=110/0", bus.rsp_valid, bus.rsp_write,
               bus.rsp_error, bus.rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL sw_rsp_pulse got=%b exp=0", bus.rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd[3];
    rd[0] = 32'h11;
    rd[1] = 32'h22;
    rd[2] = 32'h33;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive_req(1'b1, 1'b0, HSIZE_WORD, 32'(c * 4), 32'h0);
      else drive_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      set_slave(1'b1, 1'b0, (c >= 2 && c <= 4) ? rd[(c + 1) % 3] : 32'h0);
      @(negedge clk);
      if (c < 3) begin
        checks++;
        if ({bus.HTRANS, bus.HADDR} !== {HTRANS_NONSEQ, 32'(c * 4)}) begin
          failures++;
          $display("FAIL b2b_nonseq c=%0d got=%h/%h exp=2/%h", c, bus.HTRANS, bus.HADDR, c * 4);
        end
      end
      checks++;
      if (bus.rsp_valid !== (c >= 2 && c <= 4)) begin
        failures++;
        $display("FAIL b2b_rsp_valid c=%0d got=%b", c, bus.rsp_valid);
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if ({bus.rsp_rdata, bus.rsp_error} !== {rd[(c + 1) % 3], 1'b0}) begin
          failures++;
          $display("FAIL b2b_rdata c=%0d got=%h/%b exp=%h/0", c, bus.rsp_rdata, bus.rsp_error,
                   rd[(c + 1) % 3]);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    drive_req(1'b1, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
    set_slave(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    drive_req(1'b1, 1'b1, HSIZE_WORD, 32'h24, 32'h1234_5678);
    @(negedge clk);
    drive_req(1'b1, 1'b0, HSIZE_HALF, 32'h28, 32'h0);
    for (int w = 0; w < 2; w++) begin
      set_slave(1'b0, 1'b0, 32'h0);
      #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin
        failures++;
        $display("FAIL ws_ready w=%0d got=%b exp=0", w, bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if ({bus.HTRANS, bus.HADDR, bus.HWRITE, bus.rsp_valid} !==
          {HTRANS_NONSEQ, 32'h24, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL ws_hold w=%0d got=%h/%h/%b/%b exp=2/24/1/0", w, bus.HTRANS, bus.HADDR,
                 bus.HWRITE, bus.rsp_valid);
      end
    end
    set_slave(1'b1, 1'b0, 32'hA5A5_0001);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    checks++;
    if ({bus.rsp_valid, bus.rsp_write, bus.rsp_error, bus.rsp_rdata} !=={3'b100, 32'hA5A5_0001})
    begin
      failures++;
      $display("FAIL ws_rsp got=%b%b%b/%h exp=100/a5a50001", bus.rsp_valid, bus.rsp_write,
               bus.rsp_error, bus.rsp_rdata);
    end
    checks++;
    if ({bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWDATA} !==
        {HTRANS_NONSEQ, 32'h28, 3'd1, 32'h1234_5678}) begin
      failures++;
      $display("FAIL ws_next got=%h/%h/%h/%h exp=2/28/1/12345678", bus.HTRANS, bus.HADDR,
               bus.HSIZE, bus.HWDATA);
    end
    set_slave(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_write, bus.rsp_error} !== 3'b110) begin
      failures++;
      $display("FAIL ws_wr_rsp got=%b%b%b exp=110", bus.rsp_valid, bus.rsp_write, bus.rsp_error);
    end
    set_slave(1'b1, 1'b0, 32'h0000_0077);
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_write, bus.rsp_rdata} !== {2'b10, 32'h77}) begin
      failures++;
      $display("FAIL ws_rd2_rsp got=%b%b/%h exp=10/77", bus.rsp_valid, bus.rsp_write,
               bus.rsp_rdata);
    end
    set_slave(1'b1, 1'b0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_error();
    drive_req(1'b1, 1'b1, HSIZE_WORD, 32'h40, 32'h0BAD_F00D);
    set_slave(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    drive_req(1'b1, 1'b0, HSIZE_WORD, 32'h44, 32'h0);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    set_slave(1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.HTRANS, bus.rsp_valid, bus.HWDATA} !== {HTRANS_IDLE, 1'b0, 32'h0BAD_F00D}) begin
      failures++;
      $display("FAIL err_cancel got=%h/%b/%h exp=0/0/0badf00d", bus.HTRANS, bus.rsp_valid,
               bus.HWDATA);
    end
    set_slave(1'b1, 1'b1, 32'h0);
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL err_ready got=%b exp=0", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_write, bus.rsp_error} !== 3'b111) begin
      failures++;
      $display("FAIL err_rsp got=%b%b%b exp=111", bus.rsp_valid, bus.rsp_write, bus.rsp_error);
    end
    checks++;
    if ({bus.HTRANS, bus.HADDR, bus.HWRITE} !== {HTRANS_NONSEQ, 32'h44, 1'b0}) begin
      failures++;
      $display("FAIL err_reissue got=%h/%h/%b exp=2/44/0", bus.HTRANS, bus.HADDR, bus.HWRITE);
    end
    set_slave(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    set_slave(1'b1, 1'b0, 32'hBEEF_0044);
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_write, bus.rsp_error, bus.rsp_rdata} !== {3'b100, 32'hBEEF_0044})
    begin
      failures++;
      $display("FAIL err_rd_rsp got=%b%b%b/%h exp=100/beef0044", bus.rsp_valid, bus.rsp_write,
               bus.rsp_error, bus.rsp_rdata);
    end
    set_slave(1'b1, 1'b0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive_req(1'b1, 1'b0, HSIZE_HALF, 32'h3, 32'h0);
      else if (c == 1) drive_req(1'b1, 1'b1, 3'd3, 32'h8, 32'h1234);
      else drive_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      set_slave(1'b1, 1'b0, 32'hFFFF_FFFF);
      @(negedge clk);
      checks++;
      if (bus.HTRANS !== HTRANS_IDLE) begin
        failures++;
        $display("FAIL mis_idle c=%0d got=%h exp=0", c, bus.HTRANS);
      end
      if (c >= 2) begin
        checks++;
        if ({bus.rsp_valid, bus.rsp_write, bus.rsp_error, bus.rsp_rdata} !==
            {(c != 4), (c == 3), (c != 4), 32'h0} && !(c == 4 && bus.rsp_valid === 1'b0)) begin
          failures++;
          $display("FAIL mis_rsp c=%0d got=%b%b%b/%h", c, bus.rsp_valid, bus.rsp_write,
                   bus.rsp_error, bus.rsp_rdata);
        end
      end
    end
  endtask

  task automatic test_random();
    rec_t        r;
    rec_t        h;
    bit          sl_active = 0;
    bit          sl_err = 0;
    bit          sl_err_first = 0;
    int          sl_waits = 0;
    logic        sl_write = 1'b0;
    logic [31:0] sl_wdata = 32'h0;
    logic [31:0] sl_rdata = 32'h0;
    int          sl_seq = 0;
    bit          m_cancel = 0;
    bit          m_ready;
    bit          accept;
    logic        rdy;
    logic        resp;
    logic [31:0] hr;
    logic [1:0]  htrans_now;
    bit          e_err;
    logic [31:0] e_rd;
    logic [2:0]  s;
    logic [31:0] a;
    int          seq = 0;
    int          cyc = 0;
    while (cyc < 500 || (exp_q.size() != 0 && cyc < 600)) begin
      if (bus.rsp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rnd_spurious_rsp cyc=%0d got=1 exp=0", cyc);
        end else begin
          r = exp_q.pop_front();
          if (!r.mis && !out_err.exists(r.seq)) begin
            failures++;
            $display("FAIL rnd_early_rsp seq=%0d got=rsp exp=no rsp before bus completion", r.seq);
          end else begin
            e_err = r.mis ? 1'b1 : out_err[r.seq];
            e_rd  = (r.w || r.mis) ? 32'h0 : out_rdata[r.seq];
            if ({bus.rsp_write, bus.rsp_error, bus.rsp_rdata} !== {r.w, e_err, e_rd}) begin
              failures++;
              $display("FAIL rnd_rsp seq=%0d got=%b/%b/%h exp=%b/%b/%h", r.seq, bus.rsp_write,
                       bus.rsp_error, bus.rsp_rdata, r.w, e_err, e_rd);
            end
          end
        end
      end
      htrans_now = bus.HTRANS;
      if (htrans_now === HTRANS_NONSEQ) begin
        checks++;
        if (m_cancel || bus_q.size() == 0) begin
          failures++;
          $display("FAIL rnd_unexpected_nonseq cyc=%0d got=NONSEQ exp=IDLE", cyc);
        end else begin
          h = bus_q[0];
          if ({bus.HADDR, bus.HWRITE, bus.HSIZE} !== {h.addr, h.w, h.size}) begin
            failures++;
            $display("FAIL rnd_addr_phase seq=%0d got=%h/%b/%h exp=%h/%b/%h", h.seq, bus.HADDR,
                     bus.HWRITE, bus.HSIZE, h.addr, h.w, h.size);
          end
        end
      end
      if (sl_active && sl_write) begin
        checks++;
        if (bus.HWDATA !== sl_wdata) begin
          failures++;
          $display("FAIL rnd_hwdata seq=%0d got=%h exp=%h", sl_seq, bus.HWDATA, sl_wdata);
        end
      end
      // Slave response for the current data phase.
      rdy  = 1'b1;
      resp = 1'b0;
      hr   = $urandom;
      if (sl_active) begin
        if (sl_waits > 0) rdy = 1'b0;
        else if (sl_err) begin
          rdy  = sl_err_first;
          resp = 1'b1;
        end else hr = sl_rdata;
      end
      set_slave(rdy, resp, hr);
      if (cyc < 500 && $urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 6) == 0) begin
          s = 3'($urandom_range(0, 7));
          a = $urandom;
        end else begin
          s = 3'($urandom_range(0, 2));
          a = $urandom & ~((32'd1 << s) - 32'd1);
        end
        drive_req(1'b1, 1'($urandom_range(0, 1)), s, a, $urandom);
      end else drive_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      m_ready = rdy && !m_cancel;
      #1;
      checks++;
      if (bus.req_ready !== m_ready) begin
        failures++;
        $display("FAIL rnd_req_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, m_ready);
      end
      accept = bus.req_valid && m_ready;
      // Reference model update for the coming edge.
      if (rdy) begin
        if (sl_active) begin
          out_err[sl_seq]   = sl_err;
          out_rdata[sl_seq] = hr;
          sl_active = 0;
        end
        if (htrans_now === HTRANS_NONSEQ && bus_q.size() > 0) begin
          h            = bus_q.pop_front();
          sl_active    = 1;
          sl_seq       = h.seq;
          sl_write     = h.w;
          sl_wdata     = h.wdata;
          sl_rdata     = $urandom;
          sl_waits     = $urandom_range(0, 3);
          if (sl_waits == 3) sl_waits = 0;
          sl_err       = ($urandom_range(0, 7) == 0);
          sl_err_first = 0;
        end
      end else if (sl_active) begin
        if (sl_waits > 0) sl_waits--;
        else if (sl_err) sl_err_first = 1;
      end
      if (!rdy && resp) m_cancel = 1;
      else if (rdy) m_cancel = 0;
      if (accept) begin
        r.w     = bus.req_write;
        r.size  = bus.req_size;
        r.addr  = bus.req_addr;
        r.wdata = bus.req_wdata;
        r.mis   = (r.size > 3'd2) || ((r.addr % (32'd1 << r.size)) != 32'd0);
        r.seq   = seq;
        seq++;
        exp_q.push_back(r);
        if (!r.mis) bus_q.push_back(r);
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || bus_q.size() != 0) begin
      failures++;
      $display("FAIL rnd_drain got=%0d/%0d outstanding exp=0/0", exp_q.size(), bus_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    drive_req(1'b1, 1'b0, HSIZE_WORD, 32'h80, 32'h0);
    set_slave(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    drive_req(1'b1, 1'b1, HSIZE_WORD, 32'h84, 32'h5);
    @(negedge clk);
    drive_req(1'b1, 1'b0, HSIZE_WORD, 32'h88, 32'h0);
    set_slave(1'b0, 1'b0, 32'h0);
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL rm_ready got=%b exp=0", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if ({bus.HTRANS, bus.rsp_valid, bus.HADDR} !== {HTRANS_IDLE, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL rm_after_reset got=%h/%b/%h exp=0/0/0", bus.HTRANS, bus.rsp_valid,
               bus.HADDR);
    end
    resetn = 1'b1;
    drive_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    set_slave(1'b1, 1'b0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.HTRANS, bus.rsp_valid} !== {HTRANS_IDLE, 1'b0}) begin
        failures++;
        $display("FAIL rm_stale c=%0d got=%h/%b exp=0/0", c, bus.HTRANS, bus.rsp_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_misaligned();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
